// File: rtl/cla_wide_addsub_seq_if.sv
// Start/done handshake and operand/result bundle for cla_wide_addsub_seq.
// CLA_WIDE_CARRY_CHAIN_EN adds the cin operand bit.
interface cla_wide_addsub_seq_if #(
    parameter int N_CHUNKS = 2
);
    localparam int W = 16 * N_CHUNKS;

    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef CLA_WIDE_CARRY_CHAIN_EN
    logic         cin;
`endif
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;

`ifdef CLA_WIDE_CARRY_CHAIN_EN
    modport master (
        output start, op, a, b, cin,
        input  ready, busy, done, result, carry, overflow, zero
    );
    modport slave (
        input  start, op, a, b, cin,
        output ready, busy, done, result, carry, overflow, zero
    );
`else
    modport master (
        output start, op, a, b,
        input  ready, busy, done, result, carry, overflow, zero
    );
    modport slave (
        input  start, op, a, b,
        output ready, busy, done, result, carry, overflow, zero
    );
`endif
endinterface

// File: rtl/cla_wide_addsub_seq.sv
// Multi-cycle wide add/subtract: one 16-bit CLA slice reused LSB-first, carry fed back.
// Optional macro CLA_WIDE_CARRY_CHAIN_EN: slice-0 carry-in comes from the cin operand.
module cla_16bit_lcu (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] sum_o,
    output logic        c_o
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] cv;
    logic [3:0]  gg;
    logic [3:0]  pg;
    logic [3:0]  gc;
    logic        ct;

    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        cv = '0;
        ct = 1'b0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k] = &p[4*k +: 4];
        end
        // Second-level lookahead: group carries straight from c_i.
        gc[0] = c_i;
        gc[1] = gg[0] | (pg[0] & c_i);
        gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c_i);
        gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
              | (pg[2] & pg[1] & pg[0] & c_i);
        c_o   = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
              | (pg[3] & pg[2] & pg[1] & gg[0])
              | (pg[3] & pg[2] & pg[1] & pg[0] & c_i);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                ct = gc[k];
                for (int m = 0; m < j; m++) begin
                    ct = g[4*k+m] | (p[4*k+m] & ct);
                end
                cv[4*k+j] = ct;
            end
        end
    end

    assign sum_o = p ^ cv;
endmodule

// state  | meaning
// S_IDLE | waiting for start; ready=1
// S_RUN  | one 16-bit slice per cycle, cnt_q selects the slice; busy=1
// S_DONE | result and flags valid for this cycle; ready=1, start accepted
module cla_wide_addsub_seq #(
    parameter int N_CHUNKS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cla_wide_addsub_seq_if.slave   bus
);
    localparam int W  = 16 * N_CHUNKS;
    localparam int CW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N_CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          c0_q, c0_d;
    logic [W-1:0]  result_q, result_d;
    logic          carry_q, carry_d;
    logic          ovf_q, ovf_d;
    logic          zero_q, zero_d;

    logic          accept;
    logic [15:0]   add_a;
    logic [15:0]   add_b;
    logic          add_c;
    logic [15:0]   add_sum;
    logic          add_co;

    cla_16bit_lcu u_lcu (
        .a_i   (add_a),
        .b_i   (add_b),
        .c_i   (add_c),
        .sum_o (add_sum),
        .c_o   (add_co)
    );

    assign accept = bus.start && (state_q != S_RUN);

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < N_CHUNKS; i++) begin
            if (cnt_q == CW'(i)) begin
                add_a = a_q[16*i +: 16];
                add_b = b_q[16*i +: 16];
            end
        end
        add_c = (cnt_q == '0) ? c0_q : carry_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        c0_d     = c0_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < N_CHUNKS; i++) begin
                    if (cnt_q == CW'(i)) begin
                        result_d[16*i +: 16] = add_sum;
                    end
                end
                carry_d = add_co;
                if (cnt_q == CNT_LAST) begin
                    // Flags look at the fully assembled result, including this slice.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (result_d[W-1] != a_q[W-1]);
                    zero_d  = (result_d == '0);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = bus.start ? S_RUN : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            cnt_d = '0;
            a_d   = bus.a;
            b_d   = bus.op ? ~bus.b : bus.b;
`ifdef CLA_WIDE_CARRY_CHAIN_EN
            c0_d  = bus.cin;
`else
            c0_d  = bus.op;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c0_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c0_q     <= c0_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.ready    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
endmodule

// File: doc/cla_wide_addsub_seq.md
Name: cla_wide_addsub_seq

Overview:
- Multi-cycle add/subtract sequencer for operands wider than 16 bits.
- Time-multiplexes a single internal cla_16bit_lcu instance over N_CHUNKS 16-bit slices, least-significant slice first.
- Each slice's carry-out is registered and fed back as the next slice's c_in.
- Sits beside the ALU; serves wide address arithmetic and multi-word ADD/SUB, producing result plus flags with a start/done handshake.

Parameters:
- N_CHUNKS, 2, number of 16-bit slices; operand width W = 16*N_CHUNKS; legal range 1..8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request pulse; accepted only when ready=1.
- op  input  1  0 = add (a+b), 1 = subtract (a-b).
- a  input  W  operand A; sampled on the accepting edge.
- b  input  W  operand B; sampled on the accepting edge.
- ready  output  1  high in IDLE and DONE; a new start can be accepted.
- busy  output  1  high while slices are being computed (RUN).
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  W  sum/difference; held stable until the next accepted start.
- carry  output  1  carry-out of the top slice; for subtract, 1 = no borrow.
- overflow  output  1  signed overflow of the W-bit operation.
- zero  output  1  result == 0.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE; chunk counter = 0.
  - result = 0, carry = 0, overflow = 0, zero = 0, done = 0, busy = 0, ready = 1.
  - Reset overrides start and aborts any in-flight operation; no done is issued for the aborted operation.
- States:
  - IDLE: ready=1. On start=1, latch a, op, and b_eff (b if op=0, ~b if op=1); clear cnt; go to RUN.
  - RUN: busy=1, ready=0.
    - Adder inputs: a_r[16*cnt +: 16], b_eff[16*cnt +: 16].
    - Adder c_in: op_r when cnt==0, else carry_r.
    - Each edge writes the adder sum to result[16*cnt +: 16] and the adder c_out to carry_r.
    - If cnt == N_CHUNKS-1, go to DONE; otherwise cnt++.
  - DONE: done=1 for exactly this cycle; ready=1.
    - start=1 here is accepted exactly as from IDLE (back-to-back allowed); otherwise go to IDLE.
- start is ignored while busy=1. It is not queued, and the operand registers are not disturbed.
- Latency: start accepted at edge E0; done is high in the cycle after edge E0+N_CHUNKS, i.e. N_CHUNKS+1 cycles from start to done.
  - Throughput: one operation per N_CHUNKS+1 cycles.
- Flags are registered on the final RUN edge and are valid when done=1:
  - carry = final c_out.
  - overflow = (a_r[W-1] == b_eff[W-1]) && (result[W-1] != a_r[W-1]), using the final result.
  - zero = (result == 0).
- Outputs are held from DONE until the next accepted start. On that start, result and flags keep their old values until overwritten slice by slice.
  - Outputs are only guaranteed valid when done=1.
- Operand changes after the accepting edge have no effect.
- N_CHUNKS=1 degenerates to a registered 16-bit add/sub with a 2-cycle start-to-done.

Optional Feature:
- Macro: CLA_WIDE_CARRY_CHAIN_EN.
- Defined:
  - Adds input port cin (1 bit), sampled with the operands on the accepting edge.
  - Slice 0 c_in = cin_r for both add and subtract (subtract-with-borrow convention: cin=1 means no incoming borrow). This allows chaining of multi-word operations.
- Undefined:
  - No cin port.
  - Slice 0 c_in = op_r (0 for add, 1 for subtract).

Test Plan:
- Reset and idle: rst_n low for 2 cycles, then high -> ready=1, busy=0, done=0, result=0, all flags 0.
- Cross-slice carry, N_CHUNKS=2: add a=0x0000FFFF, b=0x00000001 -> done exactly 3 cycles after start; result=0x00010000, carry=0, overflow=0, zero=0.
- Subtract to zero: a=0x12345678, b=0x12345678, op=1 -> result=0, zero=1, carry=1.
- Signed overflow and wrap-around:
  - a=0x7FFFFFFF + b=0x00000001 -> result=0x80000000, overflow=1, carry=0.
  - a=0xFFFFFFFF + b=0x00000001 -> result=0, carry=1, zero=1.
- Handshake:
  - start re-pulsed during busy with other operands -> ignored; first result is unchanged.
  - start in the DONE cycle -> second done follows 3 cycles later.
  - rst_n low mid-RUN -> no done, outputs cleared.
- Optional, with CLA_WIDE_CARRY_CHAIN_EN: add 0x00000000 + 0x00000000 with cin=1 -> result=1; sub 5-3 with cin=0 -> result=1, carry=1.
